boot_loader_ins: RTL and testbench
==================================

Name: boot_loader_ins

Overview:
- Upstream feeder of the instruction BRAM (8-bit x 4096) that the CPU fetches from.
- Accepts a framed byte stream from a UART receiver and writes the payload bytes into the BRAM write port at consecutive addresses.
- Holds the CPU core in reset until a complete, valid image has been loaded.
- Frame format: 0xA5 magic, length LSB, length MSB, payload bytes, optional checksum.

Parameters:
ADDR_W, 12, BRAM byte address width; maximum image size is 2^ADDR_W bytes.
MAGIC, 8'hA5, frame start byte.
TIMEOUT_CYC, 1000000, maximum idle clock cycles allowed between bytes inside a frame.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_valid  input  1  single-cycle strobe: rx_data is valid
rx_data  input  8  received byte
bram_we  output  1  write enable to instruction BRAM port
bram_addr  output  ADDR_W  byte address for the write
bram_din  output  8  write data
cpu_rst  output  1  reset to CPU core; high while loading
done  output  1  image loaded successfully (sticky)
err  output  1  frame error (sticky until next MAGIC)
byte_cnt  output  ADDR_W+1  payload bytes written in current frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: bram_we=0, bram_addr=0, bram_din=0, cpu_rst=1, done=0, err=0, byte_cnt=0, state=IDLE, length=0, timeout counter=0, checksum=0.
- rst asserted mid-frame aborts the frame with no further writes; already-written BRAM contents are not cleared.
- No backpressure: every rx_valid pulse is consumed in the cycle it arrives.
- IDLE:
  - rx_valid with rx_data==MAGIC -> LEN_LO; clear err, byte_cnt and checksum.
  - Any other byte is ignored.
- LEN_LO: rx_valid -> length[7:0] = rx_data, go to LEN_HI.
- LEN_HI: rx_valid -> length[15:8] = rx_data.
  - length==0 or length > 2^ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Each rx_valid registers bram_addr = byte_cnt[ADDR_W-1:0] and bram_din = rx_data, and asserts bram_we for exactly one cycle.
  - Write latency: byte at cycle n produces bram_we high in cycle n+1.
  - byte_cnt increments in the same edge that registers the write; checksum ^= rx_data.
  - When byte_cnt reaches length, go to CSUM, or to DONE if the feature is disabled.
  - length == 2^ADDR_W: the last write goes to address 2^ADDR_W-1; byte_cnt reaches 2^ADDR_W, which is why it is ADDR_W+1 bits wide. There is no address wrap.
- CSUM: rx_valid -> if rx_data==checksum go to DONE, else go to ERR.
- DONE:
  - done=1 and cpu_rst=0, both from the cycle after entry.
  - All further rx bytes are ignored until rst; a new image requires rst.
- ERR:
  - err=1, cpu_rst stays 1.
  - rx_valid with MAGIC restarts the frame: go to LEN_LO, clear err.
  - Other bytes are ignored.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CSUM, a counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYC -> ERR.
  - The counter is idle (held at 0) in IDLE, DONE and ERR.
- Simultaneous events:
  - rx_valid in the same cycle the timeout reaches TIMEOUT_CYC: the byte wins and the counter clears.
  - A MAGIC byte in DATA or CSUM is treated as data or checksum, not as a restart.
- cpu_rst is a registered output, glitch-free. It is also held high in ERR.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: the frame carries a trailing XOR-of-payload checksum byte; the CSUM state checks it; a mismatch sets err.
- Not defined: the CSUM state and checksum register are removed; DATA goes straight to DONE after the last payload byte; a trailing byte is ignored in DONE.

Test Plan:
- Reset, then A5 04 00 13 00 00 00 (+ checksum 13 if enabled) -> BRAM writes addr 0..3 = 13,00,00,00; each bram_we one cycle after its rx_valid; done=1, cpu_rst falls the cycle after DONE entry; byte_cnt=4.
- A5 00 00 -> err=1, no bram_we, cpu_rst=1. Then A5 01 00 7F (+7F) -> err clears, addr0=7F, done=1.
- BOOT_CHECKSUM_EN: A5 02 00 01 02 then checksum FF (expected 03) -> err=1, done=0, cpu_rst=1; addr 0/1 written with 01/02.
- A5 02 00 11, then TIMEOUT_CYC idle cycles -> err=1 exactly at count TIMEOUT_CYC. With a byte arriving on the terminal cycle -> no error, 2nd byte written to addr1.
- Length 0x1000 with ADDR_W=12 -> 4096 writes, last addr 0xFFF, byte_cnt=0x1000, done=1. Length 0x1001 -> err after LEN_HI.
- rst pulse after 2 of 4 payload bytes -> all outputs return to reset values next cycle, no further bram_we. A fresh frame then loads normally.

Source files
------------

// File: rtl/boot_loader_ins.sv
// boot_loader_ins: framed-image loader for the 8-bit instruction BRAM.
// Frame: MAGIC, length LSB, length MSB, payload bytes[, XOR checksum].
// The payload is written to consecutive BRAM addresses starting at 0, and
// the CPU is held in reset until a complete, valid image has been loaded.
// Optional feature macro: BOOT_CHECKSUM_EN adds the trailing XOR checksum
// byte and the state that checks it.
module boot_loader_ins #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int          TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif

  state_t            state_reg, state_next;
  logic [15:0]       length_reg, length_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [ADDR_W:0]   byte_cnt_reg, byte_cnt_next;
  logic              bram_we_reg, bram_we_next;
  logic [ADDR_W-1:0] bram_addr_reg, bram_addr_next;
  logic [7:0]        bram_din_reg, bram_din_next;
  logic              cpu_rst_reg, cpu_rst_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  logic              is_magic;
  logic              in_frame;
  logic              timeout_hit;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   cnt_inc;
  logic              last_byte;

  // Shared decode used by both the next-state and the datapath logic.
  always_comb begin
    is_magic  = rx_valid && (rx_data == MAGIC);
    // The idle counter only runs while a frame is in flight.
    in_frame  = (state_reg == LEN_LO) || (state_reg == LEN_HI) || (state_reg == DATA)
`ifdef BOOT_CHECKSUM_EN
                || (state_reg == CSUM)
`endif
                ;
    // A byte arriving on the terminal cycle wins over the timeout.
    timeout_hit = in_frame && !rx_valid && (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
    len_full  = {rx_data, length_reg[7:0]};
    cnt_inc   = byte_cnt_reg + 1'b1;
    last_byte = (17'(cnt_inc) == 17'(length_reg));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a MAGIC byte inside DATA/CSUM is ordinary data.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (is_magic) state_next = LEN_LO;
      LEN_LO: if (rx_valid) state_next = LEN_HI;
      LEN_HI: if (rx_valid) begin
        if ((len_full == 16'd0) || (17'(len_full) > MAX_LEN)) state_next = ERR;
        else                                                   state_next = DATA;
      end
      DATA:   if (rx_valid && last_byte) begin
`ifdef BOOT_CHECKSUM_EN
        state_next = CSUM;
`else
        state_next = DONE;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM:   if (rx_valid) state_next = (rx_data == csum_reg) ? DONE : ERR;
`endif
      DONE:   state_next = DONE;
      ERR:    if (is_magic) state_next = LEN_LO;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = ERR;
  end

  // Datapath and status next values; the status flags follow the next state
  // so they change on the same edge the FSM enters DONE or ERR.
  always_comb begin
    length_next    = length_reg;
    byte_cnt_next  = byte_cnt_reg;
    bram_we_next   = 1'b0;
    bram_addr_next = bram_addr_reg;
    bram_din_next  = bram_din_reg;
    to_cnt_next    = '0;
`ifdef BOOT_CHECKSUM_EN
    csum_next      = csum_reg;
`endif
    if (in_frame && !rx_valid && !timeout_hit) to_cnt_next = to_cnt_reg + 1'b1;

    if (is_magic && ((state_reg == IDLE) || (state_reg == ERR))) begin
      byte_cnt_next = '0;
`ifdef BOOT_CHECKSUM_EN
      csum_next     = '0;
`endif
    end
    if (rx_valid && (state_reg == LEN_LO)) length_next[7:0]  = rx_data;
    if (rx_valid && (state_reg == LEN_HI)) length_next[15:8] = rx_data;
    if (rx_valid && (state_reg == DATA)) begin
      bram_we_next   = 1'b1;
      bram_addr_next = byte_cnt_reg[ADDR_W-1:0];
      bram_din_next  = rx_data;
      byte_cnt_next  = cnt_inc;
`ifdef BOOT_CHECKSUM_EN
      csum_next      = csum_reg ^ rx_data;
`endif
    end

    done_next    = (state_next == DONE);
    err_next     = (state_next == ERR);
    cpu_rst_next = (state_next != DONE);
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      length_reg    <= '0;
      to_cnt_reg    <= '0;
      byte_cnt_reg  <= '0;
      bram_we_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      cpu_rst_reg   <= 1'b1;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      length_reg    <= length_next;
      to_cnt_reg    <= to_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      bram_we_reg   <= bram_we_next;
      bram_addr_reg <= bram_addr_next;
      bram_din_reg  <= bram_din_next;
      cpu_rst_reg   <= cpu_rst_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
`ifdef BOOT_CHECKSUM_EN
      csum_reg      <= csum_next;
`endif
    end
  end

  assign bram_we   = bram_we_reg;
  assign bram_addr = bram_addr_reg;
  assign bram_din  = bram_din_reg;
  assign cpu_rst   = cpu_rst_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign byte_cnt  = byte_cnt_reg;

endmodule

// File: tb/tb_boot_loader_ins.sv
// tb_boot_loader_ins: directed bench for boot_loader_ins with a write
// scoreboard. Expected BRAM writes are queued as bytes are sent and checked
// (address, data, one-cycle latency) by a monitor when bram_we fires.
module tb_boot_loader_ins;
  localparam int ADDR_W = 12;
  localparam int TO     = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_din;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   byte_cnt;

  boot_loader_ins #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .cpu_rst(cpu_rst), .done(done), .err(err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] csum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every bram_we must match the oldest queued write.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {20'd0, bram_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {20'd0, bram_addr}, {20'd0, mon_e.addr});
        chk("wr_data", {24'd0, bram_din}, {24'd0, mon_e.data});
        chk("wr_latency", cyc, mon_e.cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] b, input logic [ADDR_W-1:0] a);
    wr_t e;
    e.addr = a;
    e.data = b;
    e.cyc  = cyc;
    exp_q.push_back(e);
    send(b);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"},   {31'd0, bram_we}, 32'd0);
    chk({tag, "_addr"}, {20'd0, bram_addr}, 32'd0);
    chk({tag, "_din"},  {24'd0, bram_din}, 32'd0);
    chk({tag, "_cpu"},  {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"},  {31'd0, err}, 32'd0);
    chk({tag, "_cnt"},  {19'd0, byte_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic 4-byte image.
    do_reset();
    send(8'hA5); send(8'h04); send(8'h00);
    send_wr(8'h13, 0); send_wr(8'h00, 1); send_wr(8'h00, 2);
`ifdef BOOT_CHECKSUM_EN
    send_wr(8'h00, 3);
    chk("img_pre_done", {31'd0, done}, 32'd0);
    chk("img_pre_cpu", {31'd0, cpu_rst}, 32'd1);
    send(8'h13);
`else
    chk("img_pre_done", {31'd0, done}, 32'd0);
    chk("img_pre_cpu", {31'd0, cpu_rst}, 32'd1);
    send_wr(8'h00, 3);
`endif
    chk("img_done", {31'd0, done}, 32'd1);
    chk("img_cpu", {31'd0, cpu_rst}, 32'd0);
    chk("img_cnt", {19'd0, byte_cnt}, 32'd4);
    chk("img_err", {31'd0, err}, 32'd0);
    // Bytes after DONE are ignored.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h55);
    chk("done_sticky", {31'd0, done}, 32'd1);
    chk("done_cnt", {19'd0, byte_cnt}, 32'd4);

    // Zero length is an error; a new MAGIC restarts from ERR.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h00);
    chk("len0_err", {31'd0, err}, 32'd1);
    chk("len0_cpu", {31'd0, cpu_rst}, 32'd1);
    chk("len0_done", {31'd0, done}, 32'd0);
    send(8'h7F);
    chk("err_ignore", {31'd0, err}, 32'd1);
    send(8'hA5);
    chk("restart_err_clr", {31'd0, err}, 32'd0);
    send(8'h01); send(8'h00);
    send_wr(8'h7F, 0);
`ifdef BOOT_CHECKSUM_EN
    send(8'h7F);
`endif
    chk("restart_done", {31'd0, done}, 32'd1);
    chk("restart_cnt", {19'd0, byte_cnt}, 32'd1);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum.
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00);
    send_wr(8'h01, 0); send_wr(8'h02, 1);
    send(8'hFF);
    chk("csum_err", {31'd0, err}, 32'd1);
    chk("csum_done", {31'd0, done}, 32'd0);
    chk("csum_cpu", {31'd0, cpu_rst}, 32'd1);
`endif

    // Timeout fires exactly on the TO-th idle cycle.
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00);
    send_wr(8'h11, 0);
    repeat (TO - 1) tick();
    chk("to_pre", {31'd0, err}, 32'd0);
    tick();
    chk("to_hit", {31'd0, err}, 32'd1);
    chk("to_cpu", {31'd0, cpu_rst}, 32'd1);
    // A byte on the terminal cycle wins.
    send(8'hA5); send(8'h02); send(8'h00);
    send_wr(8'h11, 0);
    repeat (TO - 1) tick();
    send_wr(8'h22, 1);
    chk("to_race_err", {31'd0, err}, 32'd0);
    chk("to_race_cnt", {19'd0, byte_cnt}, 32'd2);
`ifdef BOOT_CHECKSUM_EN
    send(8'h33);
`endif
    chk("to_race_done", {31'd0, done}, 32'd1);

    // Full-size image: 4096 bytes, no address wrap.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h10);
    csum = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] d;
      d = 8'(i * 7 + 3);
      csum ^= d;
      if (i == 4095) chk("full_pre_done", {31'd0, done}, 32'd0);
      send_wr(d, ADDR_W'(i));
    end
`ifdef BOOT_CHECKSUM_EN
    send(csum);
`endif
    chk("full_cnt", {19'd0, byte_cnt}, 32'h1000);
    chk("full_addr", {20'd0, bram_addr}, 32'hFFF);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_err", {31'd0, err}, 32'd0);

    // Oversize image is rejected after LEN_HI.
    do_reset();
    send(8'hA5); send(8'h01); send(8'h10);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_cnt", {19'd0, byte_cnt}, 32'd0);

    // Reset mid-frame aborts; a fresh frame then loads.
    do_reset();
    send(8'hA5); send(8'h04); send(8'h00);
    send_wr(8'hAA, 0); send_wr(8'hBB, 1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    send(8'hCC); send(8'hDD);
    chk("midrst_idle_cnt", {19'd0, byte_cnt}, 32'd0);
    send(8'hA5); send(8'h02); send(8'h00);
    send_wr(8'h55, 0); send_wr(8'h66, 1);
`ifdef BOOT_CHECKSUM_EN
    send(8'h33);
`endif
    chk("fresh_done", {31'd0, done}, 32'd1);
    chk("fresh_cpu", {31'd0, cpu_rst}, 32'd0);

    tick(); tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
